// File: rtl/mac_job_sequencer.sv
// rtl/mac_job_sequencer.sv - issues dot-product jobs into the FP16 MAC pipeline and returns the result
module mac_job_sequencer #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             mac_en,
  output logic             mac_first,
  output logic             mac_last,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [15:0]      mac_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_zero,
  output logic             res_subnormal,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [LEN_W-1:0]    rem;
  logic                first_pending;
  logic [PIPE_LAT-1:0] tag;
  logic                job_fire;
  logic                op_fire;
  logic                rem_last;
  logic                tag_hit;

  assign job_fire = job_valid & job_ready;
  assign op_fire  = op_valid & op_ready;
  assign rem_last = (rem == LEN_W'(1));
  assign tag_hit  = tag[PIPE_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (job_fire) begin
          state_nxt = (job_len == '0) ? HOLD : ISSUE;
        end
      end
      ISSUE: begin
        if (op_fire && rem_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_hit) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    job_ready = (state == IDLE);
    op_ready  = (state == ISSUE);
    res_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  assign res_zero      = res_valid & (res_data[14:0] == 15'd0);
  assign res_subnormal = res_valid & (res_data[14:10] == 5'd0) & (res_data[9:0] != 10'd0);

  // The tag line mirrors the MAC pipeline, which never stalls, so it shifts every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_en        <= 1'b0;
      mac_first     <= 1'b0;
      mac_last      <= 1'b0;
      mac_a         <= 16'h0000;
      mac_b         <= 16'h0000;
      rem           <= '0;
      first_pending <= 1'b0;
      tag           <= '0;
      res_data      <= 16'h0000;
    end else begin
      mac_en    <= op_fire;
      mac_first <= op_fire & first_pending;
      mac_last  <= op_fire & rem_last;
      tag       <= {tag[PIPE_LAT-2:0], mac_en & mac_last};
      if (op_fire) begin
        mac_a         <= op_a;
        mac_b         <= op_b;
        rem           <= rem - LEN_W'(1);
        first_pending <= 1'b0;
      end
      if (job_fire) begin
        rem           <= job_len;
        first_pending <= 1'b1;
        if (job_len == '0) begin
          res_data <= 16'h0000;
        end
      end
      if (state == DRAIN && tag_hit) begin
        res_data <= mac_result;
      end
    end
  end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// tb/tb_mac_job_sequencer.sv - directed self-checking bench for mac_job_sequencer
module tb_mac_job_sequencer;

  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [LEN_W-1:0] job_len = '0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [15:0]      op_a = 16'h0;
  logic [15:0]      op_b = 16'h0;
  logic             mac_en, mac_first, mac_last;
  logic [15:0]      mac_a, mac_b;
  logic [15:0]      mac_result;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [15:0]      res_data;
  logic             res_zero, res_subnormal, busy;

  mac_job_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_result(mac_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_subnormal(res_subnormal), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC stub: presents stub_val exactly PIPE_LAT cycles after the last-tagged issue, junk otherwise.
  logic [5:0]  hist = '0;
  logic [15:0] stub_val = 16'h0;
  int en_cnt = 0, first_cnt = 0, last_cnt = 0, both_cnt = 0, last_en_cyc = 0;
  always @(negedge clk) begin
    hist = {hist[4:0], mac_en & mac_last};
    mac_result = hist[5] ? stub_val : 16'h7E00;
    if (mac_en) begin
      en_cnt++;
      if (mac_first) first_cnt++;
      if (mac_last) begin
        last_cnt++;
        last_en_cyc = cyc;
      end
      if (mac_first && mac_last) both_cnt++;
    end
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_job(input int len, input logic [15:0] sv, input logic [15:0] base_a,
                        input logic [15:0] base_b, input bit gaps, output int lat, output int w);
    stub_val  = sv;
    job_len   = LEN_W'(len);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      op_valid = 1'b1;
      op_a     = base_a + 16'(i);
      op_b     = base_b + 16'(i);
      tick();
      op_valid = 1'b0;
      if (gaps) begin
        tick();
        chk("gap_mac_en", {31'd0, mac_en}, 32'd0);
        chk("gap_hold_a", {16'd0, mac_a}, {16'd0, base_a + 16'(i)});
        chk("gap_hold_b", {16'd0, mac_b}, {16'd0, base_b + 16'(i)});
      end
    end
    w = 0;
    while (!res_valid && w < 20) begin
      tick();
      w++;
    end
    chk("res_valid_timeout", {31'd0, res_valid}, 32'd1);
    lat = cyc - last_en_cyc;
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("release_idle", {29'd0, job_ready, res_valid, busy}, 32'b100);
  endtask

  int lat, w, e0, f0, l0, b0, early, unstable, jr_bad;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {25'd0, job_ready, op_ready, mac_en, mac_first, mac_last, res_valid, busy}, 32'b1000000);
    chk("reset_data", {mac_a, mac_b ^ res_data}, 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();

    // len=3 back-to-back, cycle-exact
    stub_val  = 16'h4600;
    job_len   = 8'd3;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    chk("t1_c1_ctrl", {29'd0, job_ready, op_ready, busy}, 32'b011);
    op_valid = 1'b1;
    op_a     = 16'h3C00;
    op_b     = 16'h4000;
    tick();
    chk("t1_c2_tags", {29'd0, mac_en, mac_first, mac_last}, 32'b110);
    chk("t1_c2_ops", {mac_a, mac_b}, 32'h3C00_4000);
    tick();
    chk("t1_c3_tags", {29'd0, mac_en, mac_first, mac_last}, 32'b100);
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk("t1_c4_tags", {29'd0, mac_en, mac_first, mac_last}, 32'b101);
    chk("t1_c4_opready", {31'd0, op_ready}, 32'd0);
    early = 0;
    for (int i = 5; i <= 9; i++) begin
      tick();
      if (res_valid) early++;
    end
    chk("t1_no_early_res", early, 0);
    tick();
    chk("t1_c10_valid", {31'd0, res_valid}, 32'd1);
    chk("t1_c10_data", {16'd0, res_data}, 32'h4600);
    chk("t1_c10_flags", {30'd0, res_zero, res_subnormal}, 32'd0);
    release_res();

    // single element job
    b0 = both_cnt;
    do_job(1, 16'h3C00, 16'h3C00, 16'h3C00, 1'b0, lat, w);
    chk("t2_first_last", both_cnt - b0, 1);
    chk("t2_latency", lat, PIPE_LAT + 1);
    chk("t2_data", {16'd0, res_data}, 32'h3C00);
    release_res();

    // len=4 with bubbles between issues
    e0 = en_cnt; f0 = first_cnt; l0 = last_cnt;
    do_job(4, 16'h4C00, 16'h3C00, 16'h4000, 1'b1, lat, w);
    chk("t3_en_count", en_cnt - e0, 4);
    chk("t3_first_count", first_cnt - f0, 1);
    chk("t3_last_count", last_cnt - l0, 1);
    chk("t3_latency", lat, PIPE_LAT + 1);
    chk("t3_data", {16'd0, res_data}, 32'h4C00);
    release_res();

    // empty job
    e0 = en_cnt;
    do_job(0, 16'h1234, 16'h0, 16'h0, 1'b0, lat, w);
    chk("t4_next_cycle", w, 0);
    chk("t4_no_mac", en_cnt - e0, 0);
    chk("t4_data", {16'd0, res_data}, 32'h0000);
    chk("t4_flags", {30'd0, res_zero, res_subnormal}, 32'b10);
    release_res();

    // subnormal result held under backpressure, stray job ignored
    do_job(1, 16'h0001, 16'h0400, 16'h0400, 1'b0, lat, w);
    chk("t5_flags", {30'd0, res_zero, res_subnormal}, 32'b01);
    unstable = 0;
    jr_bad   = 0;
    job_valid = 1'b1;
    job_len   = 8'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!res_valid || res_data !== 16'h0001 || !res_subnormal) unstable++;
      if (job_ready) jr_bad++;
    end
    job_valid = 1'b0;
    chk("t5_stable", unstable, 0);
    chk("t5_job_ready_low", jr_bad, 0);
    release_res();

    // reset while draining
    stub_val  = 16'hBEEF;
    job_len   = 8'd2;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    op_valid  = 1'b1;
    op_a      = 16'h1111;
    op_b      = 16'h2222;
    tick();
    tick();
    op_valid = 1'b0;
    tick();
    chk("t6_busy_drain", {30'd0, busy, op_ready}, 32'b10);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_ctrl", {25'd0, job_ready, op_ready, mac_en, mac_first, mac_last, res_valid, busy}, 32'b1000000);
    chk("t6_rst_data", {mac_a | mac_b, res_data}, 32'd0);
    @(negedge clk) rst = 1'b1;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid) early++;
    end
    chk("t6_no_stale_res", early, 0);
    do_job(2, 16'h4800, 16'h3C00, 16'h4000, 1'b0, lat, w);
    chk("t6_fresh_latency", lat, PIPE_LAT + 1);
    chk("t6_fresh_data", {16'd0, res_data}, 32'h4800);
    release_res();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mac_job_sequencer.md
Name: mac_job_sequencer

Overview:
Control block that runs dot-product jobs on the 5-stage FP16 SD4 MAC pipeline. The final stage of that pipeline does subnormal handling and produces the registered 16-bit result.
- Accepts a job descriptor (element count) and then streams operand pairs into the MAC.
- Tags each issued pair with first/last markers and tracks the last element through the fixed pipeline latency.
- Captures the final FP16 result and presents it on a valid/ready result port with classification flags.

Parameters:
LEN_W, 8, width of job element count (max 255 elements)
PIPE_LAT, 5, cycles from mac_en-qualified operands to the matching mac_result being valid

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
job_valid  input  1  job descriptor valid
job_ready  output  1  sequencer can accept a job
job_len  input  LEN_W  number of operand pairs in job
op_valid  input  1  operand pair valid
op_ready  output  1  sequencer accepts operand pair
op_a  input  16  FP16 operand A
op_b  input  16  FP16 operand B
mac_en  output  1  registered issue strobe to MAC stage 1
mac_first  output  1  issued pair is job element 0 (MAC clears accumulator)
mac_last  output  1  issued pair is final job element
mac_a  output  16  registered operand A to MAC
mac_b  output  16  registered operand B to MAC
mac_result  input  16  FP16 output of MAC final stage
res_valid  output  1  result valid
res_ready  input  1  downstream accepts result
res_data  output  16  captured FP16 result
res_zero  output  1  res_data[14:0]==0
res_subnormal  output  1  res_data[14:10]==0 and res_data[9:0]!=0
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, async):
  - State=IDLE.
  - All outputs 0 except job_ready=1.
  - mac_a, mac_b, res_data = 16'h0000.
  - Remaining-count register and tag shift register cleared.
  - In-flight MAC results are discarded. Reset mid-job needs no drain.
- States IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - job_ready=1, op_ready=0.
  - On job_valid&job_ready, latch job_len into rem.
  - If job_len==0: go to HOLD with res_data=16'h0000 (+0.0). No MAC activity.
  - Else: go to ISSUE with first_pending=1.
- ISSUE:
  - op_ready=1. Each op_valid&op_ready handshake:
    - Registers op_a/op_b onto mac_a/mac_b.
    - Asserts mac_en for exactly the next cycle.
    - mac_first=first_pending.
    - mac_last=(rem==1).
    - Decrements rem and clears first_pending.
  - op_valid low gives a bubble: mac_en=0, and mac_a/mac_b hold their previous values.
  - Handshake with rem==1 moves to DRAIN.
  - A single-element job asserts mac_first and mac_last on the same issue.
- DRAIN:
  - op_ready=0.
  - Tag shift register (depth PIPE_LAT) is fed with mac_en&mac_last every cycle and shifts unconditionally; the pipeline never stalls.
  - When the tag reaches its output (mac_result now corresponds to the last element), capture mac_result into res_data and go to HOLD.
- HOLD:
  - res_valid=1, and res_data is stable until accepted.
  - On res_ready, clear res_valid and go to IDLE. job_ready rises the same cycle as the IDLE entry.
  - res_ready while res_valid=0 is ignored.
- Latency: mac_en of last element at cycle t → mac_result sampled at end of cycle t+PIPE_LAT → res_valid high from cycle t+PIPE_LAT+1.
- Flags res_zero and res_subnormal are combinational from res_data and qualified by res_valid. The sign bit is ignored for res_zero (so -0.0 counts as zero).
- job_valid outside IDLE and op_valid outside ISSUE are ignored.
- Only one job is in flight at a time. The next job's first issue cannot overlap the previous job's drain.

Test Plan:
- len=3, op pairs (3C00,4000),(3C00,4000),(3C00,4000) back-to-back, job accepted cycle 0:
  - mac_en at cycles 2,3,4; mac_first only at 2; mac_last only at 4.
  - MAC stub drives 4600 at cycle 9 → res_valid=1 at cycle 10, res_data=4600.
- len=1 with op (3C00,3C00):
  - mac_first=mac_last=1 on the single mac_en.
  - res_valid exactly PIPE_LAT+1 cycles after that mac_en.
- len=4 with op_valid toggling 1,0,1,0,...:
  - Exactly 4 mac_en pulses with gaps; mac_a/mac_b hold during gaps.
  - Result captured only after the 4th pulse plus PIPE_LAT.
- len=0: no mac_en; res_valid next cycle, res_data=0000, res_zero=1, res_subnormal=0.
- Stub mac_result=0x0001 (subnormal), res_ready held low 10 cycles:
  - res_valid and res_data stay stable, res_subnormal=1, job_ready=0, and a new job_valid is ignored.
  - Raising res_ready returns to IDLE.
- Assert rst low during DRAIN:
  - All outputs take reset values immediately.
  - After release, the old tag does not produce a res_valid, and a fresh len=2 job completes normally.
